// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the CPU/loader data-memory arbiter.
// Holds the default memory geometry, the port-owner tag and the arbiter states.
package data_mem_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for one single-port data RAM: CPU and loader/debug port.
// Latency: grant and RAM command in the request cycle, read return one cycle later.
// Backpressure: a requester holds req until gnt; the conflict loser waits, 1 access/cycle.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,

    input  logic                ldr_req,
    input  logic                ldr_we,
    input  logic                ldr_lock,
    input  logic [ADDR_W-1:0]   ldr_addr,
    input  logic [DATA_W-1:0]   ldr_wdata,
    input  logic [DATA_W/8-1:0] ldr_be,
    output logic                ldr_gnt,
    output logic                ldr_rvalid,
    output logic [DATA_W-1:0]   ldr_rdata,

    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_t r_state;
    owner_t r_last_owner;
    logic   r_rst_q;
    logic   r_cpu_rv;
    logic   r_ldr_rv;

    logic   w_block;
    logic   w_cpu_gnt;
    logic   w_ldr_gnt;
    state_t w_state_nxt;
    owner_t w_last_nxt;

    // No grants while reset is applied nor in the first cycle after it.
    assign w_block = rst | r_rst_q;

    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ldr_gnt = 1'b0;
        if (!w_block) begin
            if (r_state == LOCK) begin
                w_ldr_gnt = ldr_req;
            end else if (cpu_req && ldr_req) begin
                w_cpu_gnt = (r_last_owner == OWN_LDR);
                w_ldr_gnt = (r_last_owner == OWN_CPU);
            end else begin
                w_cpu_gnt = cpu_req;
                w_ldr_gnt = ldr_req;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_owner;
        if (w_cpu_gnt) w_last_nxt = OWN_CPU;
        if (w_ldr_gnt) w_last_nxt = OWN_LDR;
        case (r_state)
            ARB: begin
                if (w_ldr_gnt && ldr_lock) w_state_nxt = LOCK;
            end
            LOCK: begin
                // Leaving the lock hands the next conflict to the CPU.
                if (!ldr_lock) begin
                    w_state_nxt = ARB;
                    w_last_nxt  = OWN_LDR;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB;
            r_last_owner <= OWN_LDR;
            r_rst_q      <= 1'b1;
            r_cpu_rv     <= 1'b0;
            r_ldr_rv     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_nxt;
            r_rst_q      <= 1'b0;
            r_cpu_rv     <= w_cpu_gnt & ~cpu_we;
            r_ldr_rv     <= w_ldr_gnt & ~ldr_we;
        end
    end

    assign cpu_gnt   = w_cpu_gnt;
    assign ldr_gnt   = w_ldr_gnt;

    assign mem_addr  = w_ldr_gnt ? ldr_addr  : cpu_addr;
    assign mem_wdata = w_ldr_gnt ? ldr_wdata : cpu_wdata;
    assign mem_we    = (w_cpu_gnt & cpu_we) | (w_ldr_gnt & ldr_we);
    assign mem_be    = w_cpu_gnt ? cpu_be : (w_ldr_gnt ? ldr_be : '0);

    // Read data is shared; rvalid alone tells the owner. Masked while reset is held.
    assign cpu_rvalid = r_cpu_rv & ~rst;
    assign ldr_rvalid = r_ldr_rv & ~rst;
    assign cpu_rdata  = mem_rdata;
    assign ldr_rdata  = mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal expectations, then
// random traffic compared each cycle against a transaction-level model and a RAM.
module tb_data_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [BW-1:0] cpu_be;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ldr_req, ldr_we, ldr_lock;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic [BW-1:0] ldr_be;
    logic          ldr_gnt, ldr_rvalid;
    logic [DW-1:0] ldr_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_be(ldr_be), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
        .ldr_rdata(ldr_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Environment RAM: one-cycle registered read, byte-enabled write.
    logic [DW-1:0] env_mem [DEPTH];
    always @(posedge clk) begin
        mem_rdata <= env_mem[mem_addr];
        if (mem_we) env_mem[mem_addr] <= merge(env_mem[mem_addr], mem_wdata, mem_be);
    end

    // Reference model: arbitration rules and memory contents at transaction level.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_valid = 0;
    bit            m_locked, m_last_ldr, m_after_rst;
    bit            m_rv_cpu, m_rv_ldr;
    logic [DW-1:0] m_rv_data;
    bit            ecg, elg, erc, erl;

    always @(negedge clk) begin
        if (m_valid) begin
            ecg = 0;
            elg = 0;
            if (!(rst || m_after_rst)) begin
                if (m_locked)                 elg = ldr_req;
                else if (cpu_req && ldr_req) begin
                    ecg = m_last_ldr;
                    elg = !m_last_ldr;
                end else begin
                    ecg = cpu_req;
                    elg = ldr_req;
                end
            end
            erc = m_rv_cpu && !rst;
            erl = m_rv_ldr && !rst;
            chk("cpu_gnt", cpu_gnt, ecg);
            chk("ldr_gnt", ldr_gnt, elg);
            chk("cpu_rvalid", cpu_rvalid, erc);
            chk("ldr_rvalid", ldr_rvalid, erl);
            chk("mem_we", mem_we, (ecg && cpu_we) || (elg && ldr_we));
            chk("mem_be", mem_be, ecg ? cpu_be : (elg ? ldr_be : 4'h0));
            if (ecg) chk("mem_addr_cpu", mem_addr, cpu_addr);
            if (elg) chk("mem_addr_ldr", mem_addr, ldr_addr);
            if (ecg && cpu_we) chk("mem_wdata_cpu", mem_wdata, cpu_wdata);
            if (elg && ldr_we) chk("mem_wdata_ldr", mem_wdata, ldr_wdata);
            if (erc) chk("cpu_rdata", cpu_rdata, m_rv_data);
            if (erl) chk("ldr_rdata", ldr_rdata, m_rv_data);
        end
        chk("excl_gnt", cpu_gnt & ldr_gnt, 0);
        chk("idle_quiet", (!cpu_gnt && !ldr_gnt) ? {mem_we, mem_be} : 5'h0, 0);

        if (rst) begin
            m_locked = 0; m_last_ldr = 1; m_after_rst = 1;
            m_rv_cpu = 0; m_rv_ldr = 0; m_valid = 1;
        end else if (m_valid) begin
            m_after_rst = 0;
            m_rv_cpu = ecg && !cpu_we;
            m_rv_ldr = elg && !ldr_we;
            if (ecg) begin
                m_rv_data = ref_mem[cpu_addr];
                if (cpu_we) ref_mem[cpu_addr] = merge(ref_mem[cpu_addr], cpu_wdata, cpu_be);
            end
            if (elg) begin
                m_rv_data = ref_mem[ldr_addr];
                if (ldr_we) ref_mem[ldr_addr] = merge(ref_mem[ldr_addr], ldr_wdata, ldr_be);
            end
            if (m_locked) begin
                if (!ldr_lock) m_locked = 0;
                m_last_ldr = 1;
            end else begin
                if (ecg) m_last_ldr = 0;
                if (elg) begin
                    m_last_ldr = 1;
                    m_locked   = ldr_lock;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        if ($urandom_range(0, 3) == 0) a = AW'($urandom);
        else                           a = AW'($urandom_range(0, 31));
        return a;
    endfunction

    logic cg, lg;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        env_mem[4] = 32'h0BADF00D;
        ref_mem[4] = 32'h0BADF00D;

        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        ldr_req = 0; ldr_we = 0; ldr_lock = 0; ldr_addr = '0; ldr_wdata = '0; ldr_be = '0;
        tick(); tick();

        // CPU read straight after reset: blocked one cycle, then granted.
        rst = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 10'h004; cpu_be = 4'hF;
        @(negedge clk); chk("d_gnt_after_rst", cpu_gnt, 0); chk("d_we_after_rst", mem_we, 0);
        tick();
        @(negedge clk); chk("d_rd_gnt", cpu_gnt, 1); chk("d_rd_addr", mem_addr, 32'h4);
        tick(); cpu_req = 0;
        @(negedge clk);
        chk("d_rd_rvalid", cpu_rvalid, 1); chk("d_rd_data", cpu_rdata, 32'h0BADF00D);
        chk("d_rd_ldr_rv", ldr_rvalid, 0);

        // CPU partial write.
        tick(); cpu_req = 1; cpu_we = 1; cpu_addr = 10'h005; cpu_wdata = 32'hDEADBEEF; cpu_be = 4'h3;
        @(negedge clk);
        chk("d_wr_gnt", cpu_gnt, 1); chk("d_wr_we", mem_we, 1); chk("d_wr_be", mem_be, 32'h3);
        chk("d_wr_data", mem_wdata, 32'hDEADBEEF);
        tick(); cpu_req = 0; cpu_we = 0;
        @(negedge clk); chk("d_wr_no_crv", cpu_rvalid, 0); chk("d_wr_no_lrv", ldr_rvalid, 0);

        // Both read continuously after a fresh reset: CPU, LDR, CPU, LDR.
        tick(); rst = 1;
        tick(); rst = 0;
        tick();
        cpu_req = 1; cpu_addr = 10'h001; cpu_be = 4'hF;
        ldr_req = 1; ldr_we = 0; ldr_addr = 10'h002; ldr_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("d_rr_cpu_gnt", cpu_gnt, (k % 2) == 0);
            chk("d_rr_ldr_gnt", ldr_gnt, (k % 2) == 1);
            if (k > 0) begin
                chk("d_rr_cpu_rv", cpu_rvalid, ((k - 1) % 2) == 0);
                chk("d_rr_ldr_rv", ldr_rvalid, ((k - 1) % 2) == 1);
            end
            tick();
        end
        cpu_req = 0; ldr_req = 0;
        @(negedge clk); chk("d_rr_last_lrv", ldr_rvalid, 1); chk("d_rr_last_crv", cpu_rvalid, 0);

        // Loader locks the bus for three writes while the CPU keeps requesting.
        tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 10'h011;
        @(negedge clk); chk("d_lk_pre_gnt", cpu_gnt, 1);
        tick(); ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            ldr_addr = AW'(10'h010 + i); ldr_wdata = 32'hA0A00000 + i;
            @(negedge clk);
            chk("d_lk_ldr_gnt", ldr_gnt, 1); chk("d_lk_cpu_gnt", cpu_gnt, 0);
            chk("d_lk_addr", mem_addr, 32'h10 + i); chk("d_lk_we", mem_we, 1);
            tick();
        end
        ldr_req = 0; ldr_we = 0; ldr_lock = 0;
        @(negedge clk); chk("d_lk_drop_cpu", cpu_gnt, 0);
        tick();
        @(negedge clk); chk("d_lk_exit_cpu", cpu_gnt, 1);
        tick(); cpu_req = 0;
        @(negedge clk); chk("d_lk_rb_rv", cpu_rvalid, 1); chk("d_lk_rb_data", cpu_rdata, 32'hA0A00001);

        // Reset lands on a CPU read: no return, CPU wins the next conflict.
        tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 10'h004; rst = 1;
        @(negedge clk); chk("d_rs_gnt", cpu_gnt, 0);
        tick(); rst = 0;
        @(negedge clk); chk("d_rs_no_rv", cpu_rvalid, 0); chk("d_rs_blk", cpu_gnt, 0);
        tick(); ldr_req = 1; ldr_we = 0; ldr_addr = 10'h003;
        @(negedge clk); chk("d_rs_cf_cpu", cpu_gnt, 1); chk("d_rs_cf_ldr", ldr_gnt, 0);
        tick(); cpu_req = 0;
        @(negedge clk); chk("d_rs_ldr_next", ldr_gnt, 1); chk("d_rs_crv", cpu_rvalid, 1);
        tick(); ldr_req = 0;

        // Random traffic with occasional resets and lock toggling.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            cg = cpu_gnt;
            lg = ldr_gnt;
            tick();
            if (rst) rst = 0;
            else if ($urandom_range(0, 199) == 0) rst = 1;
            if (cpu_req && cg) cpu_req = 0;
            if (!cpu_req && $urandom_range(0, 9) < 6) begin
                cpu_req = 1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = rand_addr();
                cpu_wdata = $urandom; cpu_be = 4'($urandom_range(0, 15));
            end
            if (ldr_req && lg) ldr_req = 0;
            if (!ldr_req && $urandom_range(0, 9) < 6) begin
                ldr_req = 1; ldr_we = 1'($urandom_range(0, 1)); ldr_addr = rand_addr();
                ldr_wdata = $urandom; ldr_be = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 7) == 0) ldr_lock = !ldr_lock;
        end
        cpu_req = 0; ldr_req = 0; ldr_lock = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
